// File: rtl/bc_io_pkg.sv
// Shared types and constants for the Basic Computer serial I/O ports.
package bc_io_pkg;

  localparam int unsigned INPR_WIDTH       = 8;
  localparam int unsigned DEF_CLKS_PER_BIT = 16;
  localparam int unsigned HALF_BIT_DEF     = DEF_CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  function automatic int unsigned half_bit(input int unsigned clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/bc_rx_baud_gen.sv
// Bit-period counter for the serial receiver: half-period load on start detect,
// full-period reload after every sample pulse.
module bc_rx_baud_gen
  import bc_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  input  logic load_half,
  output logic sample
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(half_bit(CLKS_PER_BIT) - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_half) begin
      cnt_d = HALF_M1;
    end else if (!run || (cnt_q == '0)) begin
      cnt_d = FULL_M1;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= FULL_M1;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sample = run && !load_half && (cnt_q == '0);

endmodule

// File: rtl/bc_input_port.sv
// Basic Computer serial input port: 8N1 receiver feeding INPR and the FGI flag.
// Define BC_INPUT_PARITY_EN to receive 8E1 frames with an even-parity check.
module bc_input_port
  import bc_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rx,
  input  logic                  fgi_clear,
  output logic                  FGI,
  output logic [INPR_WIDTH-1:0] INPR,
  output logic                  overrun,
  output logic                  frame_err
);

  localparam int unsigned BCW = $clog2(INPR_WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(INPR_WIDTH - 1);

  logic                  rx_meta_q, rx_s_q, rx_prev_q;
  logic [1:0]            arm_q;
  rx_state_e             state_q;
  logic [BCW-1:0]        bit_cnt_q;
  logic [INPR_WIDTH-1:0] shift_q, inpr_q;
  logic                  fgi_q, overrun_q, frame_err_q;
  logic                  start_det, sample, run, stop_bad;

  // Edge detection is held off until rx_prev_q carries a real line value, so a
  // line held low through reset is not mistaken for a start bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      arm_q     <= 2'd0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      if (arm_q != 2'd3) begin
        arm_q <= arm_q + 2'd1;
      end
    end
  end

  assign start_det = (state_q == StIdle) && (arm_q == 2'd3) && rx_prev_q && !rx_s_q;
  assign run       = (state_q != StIdle);

  bc_rx_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (run),
    .load_half(start_det),
    .sample   (sample)
  );

`ifdef BC_INPUT_PARITY_EN
  logic par_q;
  assign stop_bad = !rx_s_q || par_q;
`else
  assign stop_bad = !rx_s_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      inpr_q      <= '0;
      fgi_q       <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef BC_INPUT_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      if (fgi_clear) begin
        fgi_q       <= 1'b0;
        overrun_q   <= 1'b0;
        frame_err_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (start_det) begin
            state_q <= StStart;
          end
        end
        StStart: begin
          if (sample) begin
            if (rx_s_q) begin
              state_q <= StIdle;
            end else begin
              state_q   <= StData;
              bit_cnt_q <= '0;
`ifdef BC_INPUT_PARITY_EN
              par_q     <= 1'b0;
`endif
            end
          end
        end
        StData: begin
          if (sample) begin
            shift_q   <= {rx_s_q, shift_q[INPR_WIDTH-1:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
`ifdef BC_INPUT_PARITY_EN
            par_q     <= par_q ^ rx_s_q;
            if (bit_cnt_q == LAST_BIT) begin
              state_q <= StParity;
            end
`else
            if (bit_cnt_q == LAST_BIT) begin
              state_q <= StStop;
            end
`endif
          end
        end
`ifdef BC_INPUT_PARITY_EN
        StParity: begin
          if (sample) begin
            par_q   <= par_q ^ rx_s_q;
            state_q <= StStop;
          end
        end
`endif
        StStop: begin
          if (sample) begin
            state_q <= StIdle;
            // A clear in the same cycle frees INPR, so the new byte loads cleanly.
            if (stop_bad) begin
              frame_err_q <= 1'b1;
            end else if (fgi_q && !fgi_clear) begin
              overrun_q <= 1'b1;
            end else begin
              inpr_q <= shift_q;
              fgi_q  <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign FGI       = fgi_q;
  assign INPR      = inpr_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: doc/bc_input_port.md
# bc_input_port

Serial input device for the Basic Computer: receives 8N1 asynchronous frames on `rx` and loads each byte into the 8-bit input register INPR. It also drives the input flag FGI that the processor top level samples for interrupt and SKI decisions. The block sits directly upstream of the processor's `FGI` input. The controller pulses `fgi_clear` when INP transfers INPR into AC, which re-arms the port.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clk cycles per serial bit. Must be even and ≥ 4.

Ports:
- `clk`, input, 1: system clock, rising-edge.
- `reset_n`, input, 1: reset, asynchronous, active-low.
- `rx`, input, 1: serial line; idle high; asynchronous to `clk`.
- `fgi_clear`, input, 1: one-cycle pulse from the controller on INP execution.
- `FGI`, output, 1: input flag; 1 = INPR holds an unread byte.
- `INPR`, output, 8: received byte.
- `overrun`, output, 1: sticky; a byte arrived while FGI = 1.
- `frame_err`, output, 1: sticky; stop bit sampled 0.

## Operation
- Reset values:
  - FGI = 0, INPR = 8'h00, overrun = 0, frame_err = 0.
  - State = IDLE; synchronizer flops = 1.
- `rx` passes through a 2-flop synchronizer. All decisions use the synchronized value.
- State machine: IDLE → START → DATA → (PARITY) → STOP → IDLE.
  - IDLE: a high-to-low transition of synchronized rx starts a CLKS_PER_BIT/2 count and moves to START. A line held low out of reset is ignored until it returns high.
  - START: at half-bit, resample. If rx = 1, the start was false; return to IDLE with no flag change. If rx = 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles. 8 bits, LSB first, into a shift register. After bit 7, go to STOP (or PARITY).
  - STOP: sample one bit period later, then return to IDLE in the same cycle so the next start edge can be detected immediately.
- On the stop sample:
  - rx = 0: set frame_err and discard the byte. INPR and FGI are unchanged.
  - rx = 1 and FGI = 0: load INPR and set FGI.
  - rx = 1 and FGI = 1: set overrun; INPR keeps the old byte.
- `fgi_clear`:
  - Clears FGI, overrun and frame_err on the next edge.
  - INPR is unchanged.
- `fgi_clear` in the same cycle as a good stop sample:
  - The new byte loads and FGI stays 1.
  - No overrun is recorded; overrun and frame_err clear.
- `reset_n` asserted mid-frame: abort immediately and discard the partial byte. All outputs return to their reset values.

## Timing
- Define cycle 0 as the edge at which synchronizer stage 1 first captures rx = 0.
- FGI, INPR, overrun and frame_err update at cycle 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT:
  - 154 with defaults.
  - 170 with parity compiled in.
- Data bit k is sampled at cycle 2 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
- FGI falls 1 cycle after `fgi_clear` is sampled high.
- All outputs are registered. No combinational path runs from any input to any output.

## Configuration
- `BC_INPUT_PARITY_EN`:
  - Defined: the frame is 8E1. A PARITY state samples a 9th bit between DATA and STOP. An even-parity mismatch sets frame_err and discards the byte, using the same rules as a bad stop bit.
  - Undefined: 8N1, and the PARITY state does not exist.

## Structure
- Shared package `bc_io_pkg`:
  - State enum (IDLE, START, DATA, PARITY, STOP).
  - `INPR_WIDTH = 8`.
  - Localparam for the half-bit count.
- One sub-module, `bc_rx_baud_gen`:
  - Bit-period counter with a load input: half-period on start detect, full period otherwise.
  - Emits a one-cycle `sample` pulse.
  - Counts in $clog2(CLKS_PER_BIT) bits and wraps to reload; it never free-runs past CLKS_PER_BIT−1.

## Test plan
- Reset, then frame 8'hA5 at 16 clk/bit → INPR = 8'hA5 and FGI = 1 exactly at cycle 154; overrun = 0 and frame_err = 0.
- 8'h3C received, no clear, then 8'h7E → INPR stays 8'h3C and overrun = 1. A `fgi_clear` pulse then gives FGI = 0 and overrun = 0 one cycle later.
- Frame 8'h55 with stop bit = 0 → frame_err = 1, FGI = 0, INPR = 8'h00.
- Low glitch of 4 cycles on `rx` in IDLE → remains IDLE; no flag changes; the next valid frame 8'h01 is received correctly.
- `fgi_clear` coincident with the stop sample of 8'hC3 while FGI = 1 → INPR = 8'hC3, FGI = 1, overrun = 0.
- `reset_n` low during data bit 4 → all outputs 0 immediately. A following frame 8'hFF is received with FGI = 1 at cycle 154 from its start.
